// File: rtl/toi2s_pkg.sv
// -----------------------------------------------------------------------------
// toi2s_pkg
// Shared types and constants for the amplifier-bus I2C initiator.
//   amp_i2c_state_t      : transaction FSM states
//   amp_i2c_qphase_t     : SCL quarter-period phase (q0..q3)
//   AMP_I2C_QDIV_DEFAULT : clk cycles per SCL quarter (about 100 kHz at 25 MHz)
//   amp_i2c_bus_levels() : {scl, sdao} levels for a given state/quarter
// -----------------------------------------------------------------------------
package toi2s_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START,
      ST_TXBYTE,
      ST_TXACK,
      ST_RESTART,
      ST_RXBYTE,
      ST_RXACK,
      ST_STOP,
      ST_DONE
   } amp_i2c_state_t;

   typedef logic [1:0] amp_i2c_qphase_t;

   localparam int unsigned AMP_I2C_QDIV_DEFAULT = 62;

   // Returns {scl, sdao}. Data slots hold SCL low in q0/q1 and high in q2/q3;
   // the framing states move SDA while SCL is high to form START/RESTART/STOP.
   function automatic logic [1:0] amp_i2c_bus_levels(input amp_i2c_state_t  st,
                                                     input amp_i2c_qphase_t ph,
                                                     input logic            txbit);
      case (st)
         ST_START:                      return {1'b1, ~ph[1]};
         ST_TXBYTE:                     return {ph[1], txbit};
         ST_TXACK, ST_RXBYTE, ST_RXACK: return {ph[1], 1'b1};
         ST_RESTART:                    return {(ph != 2'd0), ~ph[1]};
         ST_STOP:                       return {(ph != 2'd0), ph[1]};
         default:                       return 2'b11;
      endcase
   endfunction

endpackage

// File: rtl/amp_i2c_qtick.sv
// -----------------------------------------------------------------------------
// amp_i2c_qtick
// SCL quarter-period divider. Counts QDIV clks per quarter and advances a
// 2-bit quarter phase at the end of each quarter.
//   clk, resetb : system clock, asynchronous active-low reset
//   restart     : synchronous restart; holds count and phase at zero
//   qtick       : high on the last clk of every quarter
//   phase       : current quarter (0..3)
// -----------------------------------------------------------------------------
module amp_i2c_qtick
   import toi2s_pkg::*;
#(
   parameter int unsigned QDIV = AMP_I2C_QDIV_DEFAULT
) (
   input  logic       clk,
   input  logic       resetb,
   input  logic       restart,
   output logic       qtick,
   output logic [1:0] phase
);

   localparam int unsigned   CW       = (QDIV > 1) ? $clog2(QDIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(QDIV - 1);

   logic [CW-1:0]   cnt_q;
   amp_i2c_qphase_t phase_q;

   assign qtick = !restart && (cnt_q == CNT_LAST);
   assign phase = phase_q;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         cnt_q   <= '0;
         phase_q <= '0;
      end else if (restart) begin
         cnt_q   <= '0;
         phase_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_q   <= '0;
         phase_q <= phase_q + 2'd1;
      end else begin
         cnt_q   <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/amp_i2c_master.sv
// -----------------------------------------------------------------------------
// amp_i2c_master
// I2C initiator issuing single-register writes/reads to the external amplifier.
//   clk, resetb      : system clock, asynchronous active-low reset
//   start, rw        : one-cycle request; rw 0 = write, 1 = read
//   dev_addr         : 7-bit device address
//   reg_addr, wdata  : register address and write data
//   rdata            : read data, updated at the end of an ACKed read
//   busy, done, nack : in progress / one-cycle completion / sticky ACK error
//   scl              : push-pull SCL
//   sdai, sdao       : SDA pad input / open-drain control (0 = pull low)
// -----------------------------------------------------------------------------
module amp_i2c_master
   import toi2s_pkg::*;
#(
   parameter int unsigned QDIV = AMP_I2C_QDIV_DEFAULT
) (
   input  logic       clk,
   input  logic       resetb,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] dev_addr,
   input  logic [7:0] reg_addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       done,
   output logic       nack,
   output logic       scl,
   input  logic       sdai,
   output logic       sdao
);

   amp_i2c_state_t  state_q, state_d;
   amp_i2c_qphase_t ph_d;
   logic            rw_q, rw_d;
   logic [6:0]      dev_q, dev_d;
   logic [7:0]      reg_q, reg_d, wdata_q, wdata_d;
   logic [7:0]      sh_q, sh_d;
   logic [3:0]      bitcnt_q, bitcnt_d;
   logic [1:0]      byte_q, byte_d;
   logic            ack_q, ack_d, nack_q, nack_d;
   logic            busy_q, busy_d, done_q, done_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            scl_q, sdao_q;

   logic            qtick, restart, q_end, q_samp;
   logic [1:0]      phase;

   // Holding the divider in restart while idle makes the first quarter after
   // acceptance exactly QDIV clks long.
   assign restart = (state_q == ST_IDLE);
   assign q_end   = qtick && (phase == 2'd3);
   assign q_samp  = qtick && (phase == 2'd2);

   amp_i2c_qtick #(.QDIV(QDIV)) u_qtick (
      .clk     (clk),
      .resetb  (resetb),
      .restart (restart),
      .qtick   (qtick),
      .phase   (phase)
   );

   always_comb begin
      state_d  = state_q;
      rw_d     = rw_q;
      dev_d    = dev_q;
      reg_d    = reg_q;
      wdata_d  = wdata_q;
      sh_d     = sh_q;
      bitcnt_d = bitcnt_q;
      byte_d   = byte_q;
      ack_d    = ack_q;
      nack_d   = nack_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      rdata_d  = rdata_q;
      case (state_q)
         ST_IDLE: if (start) begin
            rw_d    = rw;
            dev_d   = dev_addr;
            reg_d   = reg_addr;
            wdata_d = wdata;
            nack_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = ST_START;
         end
         ST_START: if (q_end) begin
            sh_d     = {dev_q, 1'b0};
            bitcnt_d = '0;
            byte_d   = 2'd0;
            state_d  = ST_TXBYTE;
         end
         ST_TXBYTE: if (q_end) begin
            sh_d     = {sh_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) state_d = ST_TXACK;
         end
         ST_TXACK: begin
            if (q_samp) ack_d = sdai;
            if (q_end) begin
               bitcnt_d = '0;
               if (ack_q) begin
                  nack_d  = 1'b1;
                  state_d = ST_STOP;
               end else begin
                  // byte_q: 0 = address+W, 1 = register, 2 = data or address+R
                  case (byte_q)
                     2'd0: begin
                        sh_d    = reg_q;
                        byte_d  = 2'd1;
                        state_d = ST_TXBYTE;
                     end
                     2'd1: if (rw_q) begin
                        state_d = ST_RESTART;
                     end else begin
                        sh_d    = wdata_q;
                        byte_d  = 2'd2;
                        state_d = ST_TXBYTE;
                     end
                     default: state_d = rw_q ? ST_RXBYTE : ST_STOP;
                  endcase
               end
            end
         end
         ST_RESTART: if (q_end) begin
            sh_d     = {dev_q, 1'b1};
            byte_d   = 2'd2;
            bitcnt_d = '0;
            state_d  = ST_TXBYTE;
         end
         ST_RXBYTE: begin
            if (q_samp) sh_d = {sh_q[6:0], sdai};
            if (q_end) begin
               bitcnt_d = bitcnt_q + 4'd1;
               if (bitcnt_q == 4'd7) state_d = ST_RXACK;
            end
         end
         ST_RXACK: if (q_end) state_d = ST_STOP;
         ST_STOP: if (q_end) begin
            if (rw_q && !nack_q) rdata_d = sh_q;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Phase of the quarter that begins at the next edge, so the bus pins
      // can be registered in step with the state.
      ph_d = restart ? '0 : (qtick ? phase + 2'd1 : phase);
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q  <= ST_IDLE;
         rw_q     <= 1'b0;
         dev_q    <= '0;
         reg_q    <= '0;
         wdata_q  <= '0;
         sh_q     <= '0;
         bitcnt_q <= '0;
         byte_q   <= '0;
         ack_q    <= 1'b0;
         nack_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rdata_q  <= '0;
         scl_q    <= 1'b1;
         sdao_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         rw_q     <= rw_d;
         dev_q    <= dev_d;
         reg_q    <= reg_d;
         wdata_q  <= wdata_d;
         sh_q     <= sh_d;
         bitcnt_q <= bitcnt_d;
         byte_q   <= byte_d;
         ack_q    <= ack_d;
         nack_q   <= nack_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         rdata_q  <= rdata_d;
         {scl_q, sdao_q} <= amp_i2c_bus_levels(state_d, ph_d, sh_d[7]);
      end
   end

   assign rdata = rdata_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign nack  = nack_q;
   assign scl   = scl_q;
   assign sdao  = sdao_q;

endmodule

// File: tb/tb_amp_i2c_master.sv
// -----------------------------------------------------------------------------
// tb_amp_i2c_master
// Two initiators (QDIV 62 and QDIV 2) share one open-drain bus with a register
// slave at address 0x2C. The bus monitor decodes START/STOP/bytes and compares
// them against tokens queued when each transaction is launched.
// -----------------------------------------------------------------------------
module tb_amp_i2c_master;

   localparam int unsigned Q0       = 62;
   localparam int unsigned Q1       = 2;
   localparam logic [6:0]  SLV_ADDR = 7'h2C;
   localparam logic [8:0]  TOK_S    = 9'h100;
   localparam logic [8:0]  TOK_P    = 9'h101;

   typedef struct {
      int         inst;
      logic       rw;
      logic [6:0] dev;
      logic [7:0] ra;
      logic [7:0] wdat;
      logic [7:0] sdat;
      int         nack_at;
      int         quarters;
      logic       exp_nack;
      logic [7:0] exp_rdata;
   } txn_t;

   logic       clk = 1'b0;
   logic       resetb = 1'b0;
   logic       start0 = 1'b0, start1 = 1'b0, rw = 1'b0;
   logic [6:0] dev = '0;
   logic [7:0] regad = '0, wd = '0;
   logic [7:0] rdata0, rdata1;
   logic       busy0, busy1, done0, done1, nack0, nack1;
   logic       scl0, scl1, sdao0, sdao1;
   logic       sl_drv = 1'b1;
   logic       bus_scl, bus_sda;

   assign bus_scl = scl0 & scl1;
   assign bus_sda = sdao0 & sdao1 & sl_drv;

   always #5 clk = ~clk;

   amp_i2c_master #(.QDIV(Q0)) u_dut0 (
      .clk(clk), .resetb(resetb), .start(start0), .rw(rw), .dev_addr(dev),
      .reg_addr(regad), .wdata(wd), .rdata(rdata0), .busy(busy0), .done(done0),
      .nack(nack0), .scl(scl0), .sdai(bus_sda), .sdao(sdao0)
   );

   amp_i2c_master #(.QDIV(Q1)) u_dut1 (
      .clk(clk), .resetb(resetb), .start(start1), .rw(rw), .dev_addr(dev),
      .reg_addr(regad), .wdata(wd), .rdata(rdata1), .busy(busy1), .done(done1),
      .nack(nack1), .scl(scl1), .sdai(bus_sda), .sdao(sdao1)
   );

   int checks = 0;
   int passed = 0;
   logic [8:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   task automatic emit(input logic [8:0] tok);
      logic [8:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         $display("FAIL bus_token: got 0x%0h, required none", tok);
      end else begin
         e = exp_q.pop_front();
         chk("bus_token", {23'd0, tok}, {23'd0, e});
      end
   endtask

   // ---------------- slave + bus monitor ----------------
   logic       prev_scl = 1'b1, prev_sda = 1'b1;
   int         mode = 0, bitn = 0, byten = 0, sl_nack_at = 0;
   logic [7:0] sh = '0, txsh = '0, sl_txdata = '0;
   logic       first = 1'b0, addr_ok = 1'b0, rd = 1'b0, acked = 1'b0, in_txn = 1'b0;

   always @(negedge clk) begin
      if (!resetb) begin
         mode = 0; sl_drv = 1'b1; in_txn = 1'b0;
      end else if (bus_scl && prev_scl && prev_sda && !bus_sda) begin
         if (!in_txn) begin byten = 0; in_txn = 1'b1; end
         emit(TOK_S);
         mode = 1; bitn = 0; first = 1'b1; sl_drv = 1'b1;
      end else if (bus_scl && prev_scl && !prev_sda && bus_sda) begin
         emit(TOK_P);
         mode = 0; in_txn = 1'b0; sl_drv = 1'b1;
      end else if (bus_scl && !prev_scl) begin
         case (mode)
            1: begin
               sh = {sh[6:0], bus_sda};
               bitn++;
               if (bitn == 8) begin emit({1'b0, sh}); byten++; end
            end
            3: bitn++;
            4: chk("master_nack_bit", {31'd0, bus_sda}, 32'd1);
            default: ;
         endcase
      end else if (!bus_scl && prev_scl) begin
         case (mode)
            1: if (bitn == 8) begin
               if (first) begin
                  addr_ok = (sh[7:1] == SLV_ADDR);
                  rd      = sh[0];
                  first   = 1'b0;
                  acked   = addr_ok;
               end else begin
                  acked = addr_ok && (byten != sl_nack_at);
               end
               mode = 2; sl_drv = !acked;
            end
            2: begin
               sl_drv = 1'b1;
               if (!acked) mode = 0;
               else if (rd) begin
                  mode = 3; bitn = 0; sl_drv = sl_txdata[7];
                  txsh = {sl_txdata[6:0], 1'b0};
               end else begin
                  mode = 1; bitn = 0;
               end
            end
            3: if (bitn == 8) begin
               mode = 4; sl_drv = 1'b1;
            end else begin
               sl_drv = txsh[7]; txsh = {txsh[6:0], 1'b0};
            end
            4: mode = 0;
            default: ;
         endcase
      end
      prev_scl = bus_scl;
      prev_sda = sdao0 & sdao1 & sl_drv;
   end

   // ---------------- transaction driver ----------------
   task automatic run_txn(input txn_t t, input int glitch_at, input int reset_at);
      int   q, cnt;
      logic d, b, nk, s, o;
      logic [7:0] r;
      q = (t.inst == 0) ? int'(Q0) : int'(Q1);
      sl_txdata  = t.sdat;
      sl_nack_at = t.nack_at;
      exp_q.push_back(TOK_S);
      exp_q.push_back({1'b0, t.dev, 1'b0});
      if (t.dev == SLV_ADDR) begin
         exp_q.push_back({1'b0, t.ra});
         if (t.nack_at != 2) begin
            if (t.rw) begin
               exp_q.push_back(TOK_S);
               exp_q.push_back({1'b0, t.dev, 1'b1});
            end else begin
               exp_q.push_back({1'b0, t.wdat});
            end
         end
      end
      exp_q.push_back(TOK_P);

      @(negedge clk);
      rw = t.rw; dev = t.dev; regad = t.ra; wd = t.wdat;
      if (t.inst == 0) start0 = 1'b1; else start1 = 1'b1;
      cnt = 0;
      while (1) begin
         @(negedge clk);
         cnt++;
         start0 = 1'b0; start1 = 1'b0;
         d  = (t.inst == 0) ? done0 : done1;
         b  = (t.inst == 0) ? busy0 : busy1;
         nk = (t.inst == 0) ? nack0 : nack1;
         if (cnt == 1) begin
            chk("busy_rise", {31'd0, b}, 32'd1);
            chk("nack_clear_on_accept", {31'd0, nk}, 32'd0);
         end
         if (cnt == glitch_at + 1) chk("busy_hold_ignored_start", {31'd0, b}, 32'd1);
         if (d) break;
         if (cnt == glitch_at) begin
            rw = ~t.rw; dev = 7'h55; regad = 8'hEE; wd = 8'hFF;
            if (t.inst == 0) start0 = 1'b1; else start1 = 1'b1;
         end
         if (cnt == reset_at) begin
            resetb = 1'b0;
            #1;
            s = (t.inst == 0) ? scl0 : scl1;
            o = (t.inst == 0) ? sdao0 : sdao1;
            b = (t.inst == 0) ? busy0 : busy1;
            r = (t.inst == 0) ? rdata0 : rdata1;
            chk("rst_mid_scl", {31'd0, s}, 32'd1);
            chk("rst_mid_sdao", {31'd0, o}, 32'd1);
            chk("rst_mid_busy", {31'd0, b}, 32'd0);
            chk("rst_mid_rdata", {24'd0, r}, 32'd0);
            chk("abort_tokens_left", exp_q.size(), 32'd3);
            exp_q.delete();
            repeat (3) @(negedge clk);
            resetb = 1'b1;
            return;
         end
         if (cnt >= 200 * q + 10) begin
            checks++;
            $display("FAIL done_timeout: got no done after %0d clks, required %0d", cnt, 1 + t.quarters * q);
            exp_q.delete();
            return;
         end
      end
      r = (t.inst == 0) ? rdata0 : rdata1;
      chk("done_cycles", cnt, 1 + t.quarters * q);
      chk("busy_low_at_done", {31'd0, b}, 32'd0);
      chk("nack", {31'd0, nk}, {31'd0, t.exp_nack});
      chk("rdata", {24'd0, r}, {24'd0, t.exp_rdata});
      chk("tokens_consumed", exp_q.size(), 32'd0);
      exp_q.delete();
      @(negedge clk);
      d = (t.inst == 0) ? done0 : done1;
      chk("done_one_cycle", {31'd0, d}, 32'd0);
   endtask

   txn_t tbl[8];
   txn_t hs;

   initial begin
      //          inst rw    dev     ra     wdat   sdat  nack_at qtrs nack  rdata
      tbl[0] = '{0, 1'b0, 7'h2C, 8'h05, 8'hA5, 8'h00, 0, 116, 1'b0, 8'h00};
      tbl[1] = '{0, 1'b1, 7'h2C, 8'h10, 8'h00, 8'h3C, 0, 156, 1'b0, 8'h3C};
      tbl[2] = '{0, 1'b0, 7'h11, 8'h22, 8'h33, 8'h00, 0,  44, 1'b1, 8'h3C};
      tbl[3] = '{0, 1'b1, 7'h11, 8'h10, 8'h00, 8'h77, 0,  44, 1'b1, 8'h3C};
      tbl[4] = '{1, 1'b0, 7'h2C, 8'h05, 8'hA5, 8'h00, 0, 116, 1'b0, 8'h00};
      tbl[5] = '{1, 1'b1, 7'h2C, 8'h7E, 8'h00, 8'hC3, 0, 156, 1'b0, 8'hC3};
      tbl[6] = '{1, 1'b0, 7'h2C, 8'h40, 8'h99, 8'h00, 2,  80, 1'b1, 8'hC3};
      tbl[7] = '{1, 1'b1, 7'h2C, 8'h40, 8'h00, 8'h5A, 2,  80, 1'b1, 8'hC3};

      resetb = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_scl", {30'd0, scl0, scl1}, 32'd3);
      chk("reset_sdao", {30'd0, sdao0, sdao1}, 32'd3);
      chk("reset_busy", {30'd0, busy0, busy1}, 32'd0);
      chk("reset_done", {30'd0, done0, done1}, 32'd0);
      chk("reset_nack", {30'd0, nack0, nack1}, 32'd0);
      chk("reset_rdata", {16'd0, rdata0, rdata1}, 32'd0);
      resetb = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_txn(tbl[i], -1, -1);

      // start pulsed mid-write with different request fields must be ignored
      hs = '{0, 1'b0, 7'h2C, 8'h05, 8'hA5, 8'h00, 0, 116, 1'b0, 8'h3C};
      run_txn(hs, 3000, -1);

      // reset during bit 3 of the register byte, then a clean write
      run_txn(hs, -1, 3348);
      repeat (4) @(negedge clk);
      hs.exp_rdata = 8'h00;
      run_txn(hs, -1, -1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
